// File: rtl/frog_objects_mux.sv
// Per-pixel priority compositor for the object drawers plus frog/hazard overlap
// detection with a one-shot per-frame collision event and per-frame hit summary.
module frog_objects_mux #(
    parameter int          NUM_OBJ     = 4,
    parameter logic [7:0]  TRANSPARENT = 8'hFF
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   startOfFrame,
    input  logic [NUM_OBJ-1:0]     draw_req,
    input  logic [8*NUM_OBJ-1:0]   obj_RGB,
    input  logic [7:0]             background_RGB,
    output logic [7:0]             mVGA_RGB,
    output logic                   collision_pulse,
    output logic [NUM_OBJ-1:0]     collision_mask,
    output logic                   frame_collision
);

    logic [NUM_OBJ-1:0] eff;
    logic [NUM_OBJ-1:0] hit;
    logic [NUM_OBJ-1:0] hit_accum;
    logic [7:0]         pixel;
    logic               armed;
    logic               armed_next;
    logic               pulse_fire;

    // Scan from lowest priority upward so the lowest effective index overwrites last.
    always_comb begin
        eff   = '0;
        hit   = '0;
        pixel = background_RGB;
        for (int k = NUM_OBJ - 1; k >= 0; k--) begin
            eff[k] = draw_req[k] && (obj_RGB[8*k +: 8] != TRANSPARENT);
            if (eff[k]) begin
                pixel = obj_RGB[8*k +: 8];
            end
        end
        for (int k = 1; k < NUM_OBJ; k++) begin
            hit[k] = eff[0] && eff[k];
        end
    end

    assign armed_next = startOfFrame | armed;
    assign pulse_fire = armed_next & (|hit);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mVGA_RGB        <= 8'h00;
            collision_pulse <= 1'b0;
            collision_mask  <= '0;
            frame_collision <= 1'b0;
            hit_accum       <= '0;
            armed           <= 1'b1;
        end else begin
            mVGA_RGB        <= pixel;
            collision_pulse <= pulse_fire;
            armed           <= armed_next & ~pulse_fire;
            // On a frame boundary the current pixel already belongs to the new frame.
            if (startOfFrame) begin
                collision_mask  <= hit_accum;
                frame_collision <= |hit_accum;
                hit_accum       <= hit;
            end else begin
                hit_accum       <= hit_accum | hit;
            end
        end
    end

endmodule

// File: tb/tb_frog_objects_mux.sv
// Directed testbench for frog_objects_mux: compositing priority, transparency,
// one-shot collision pulse, per-frame summary and asynchronous reset.
module tb_frog_objects_mux;

    logic        clk;
    logic        rst;
    logic        sof;
    logic [3:0]  req;
    logic [7:0]  obj [4];
    logic [31:0] obj_rgb;
    logic [7:0]  bg;
    logic [7:0]  vga;
    logic        pulse;
    logic [3:0]  mask;
    logic        fcol;

    int errors = 0;
    int checks = 0;

    assign obj_rgb = {obj[3], obj[2], obj[1], obj[0]};

    frog_objects_mux #(.NUM_OBJ(4), .TRANSPARENT(8'hFF)) dut (
        .CLK             (clk),
        .RESET           (rst),
        .startOfFrame    (sof),
        .draw_req        (req),
        .obj_RGB         (obj_rgb),
        .background_RGB  (bg),
        .mVGA_RGB        (vga),
        .collision_pulse (pulse),
        .collision_mask  (mask),
        .frame_collision (fcol)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [3:0] r);
        sof = s;
        req = r;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (vga !== 8'h00) begin errors++; $display("[TB] FAIL reset_rgb: got %h expected 00", vga); end
        checks++; if (pulse !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulse: got %b expected 0", pulse); end
        checks++; if (mask !== 4'b0000) begin errors++; $display("[TB] FAIL reset_mask: got %b expected 0000", mask); end
        checks++; if (fcol !== 1'b0) begin errors++; $display("[TB] FAIL reset_fcol: got %b expected 0", fcol); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_background();
        bg = 8'h1C;
        drive(1'b0, 4'b0000);
        tick();
        checks++; if (vga !== 8'h1C) begin errors++; $display("[TB] FAIL bg_rgb: got %h expected 1c", vga); end
        checks++; if (pulse !== 1'b0) begin errors++; $display("[TB] FAIL bg_pulse: got %b expected 0", pulse); end
        checks++; if (mask !== 4'b0000) begin errors++; $display("[TB] FAIL bg_mask: got %b expected 0000", mask); end
    endtask

    task automatic test_priority();
        obj[1] = 8'h2E;
        obj[2] = 8'h3E;
        drive(1'b0, 4'b0110);
        tick();
        checks++; if (vga !== 8'h2E) begin errors++; $display("[TB] FAIL prio_12: got %h expected 2e", vga); end
        checks++; if (pulse !== 1'b0) begin errors++; $display("[TB] FAIL prio_12_pulse: got %b expected 0", pulse); end
        obj[0] = 8'hE0;
        drive(1'b0, 4'b0111);
        tick();
        checks++; if (vga !== 8'hE0) begin errors++; $display("[TB] FAIL prio_012: got %h expected e0", vga); end
        // Frog over hazards 1 and 2 while armed since reset
        checks++; if (pulse !== 1'b1) begin errors++; $display("[TB] FAIL prio_012_pulse: got %b expected 1", pulse); end
    endtask

    task automatic test_transparency();
        // Frame boundary publishes the partial accumulation since reset (0110)
        drive(1'b1, 4'b0000);
        tick();
        checks++; if (mask !== 4'b0110) begin errors++; $display("[TB] FAIL partial_mask: got %b expected 0110", mask); end
        checks++; if (fcol !== 1'b1) begin errors++; $display("[TB] FAIL partial_fcol: got %b expected 1", fcol); end
        checks++; if (vga !== 8'h1C) begin errors++; $display("[TB] FAIL sof_bg: got %h expected 1c", vga); end
        obj[0] = 8'hFF;
        obj[1] = 8'h2E;
        drive(1'b0, 4'b0011);
        tick();
        checks++; if (vga !== 8'h2E) begin errors++; $display("[TB] FAIL transp_rgb: got %h expected 2e", vga); end
        checks++; if (pulse !== 1'b0) begin errors++; $display("[TB] FAIL transp_pulse: got %b expected 0", pulse); end
    endtask

    task automatic test_collision();
        obj[0] = 8'hE0;
        obj[1] = 8'h2E;
        obj[2] = 8'h3E;
        obj[3] = 8'h4E;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'b0101);
            tick();
            checks++;
            if (pulse !== (i == 0)) begin
                errors++;
                $display("[TB] FAIL coll_pulse_%0d: got %b expected %b", i, pulse, (i == 0));
            end
        end
        checks++; if (vga !== 8'hE0) begin errors++; $display("[TB] FAIL coll_rgb: got %h expected e0", vga); end
        drive(1'b0, 4'b1001);
        tick();
        checks++; if (pulse !== 1'b0) begin errors++; $display("[TB] FAIL coll_second: got %b expected 0", pulse); end
        drive(1'b0, 4'b0000);
        tick();
        checks++; if (mask !== 4'b0110) begin errors++; $display("[TB] FAIL mask_hold_old: got %b expected 0110", mask); end
        drive(1'b1, 4'b0000);
        tick();
        checks++; if (mask !== 4'b1100) begin errors++; $display("[TB] FAIL coll_mask: got %b expected 1100", mask); end
        checks++; if (fcol !== 1'b1) begin errors++; $display("[TB] FAIL coll_fcol: got %b expected 1", fcol); end
        checks++; if (pulse !== 1'b0) begin errors++; $display("[TB] FAIL coll_sof_pulse: got %b expected 0", pulse); end
        // Frame with the frog absent: hazard alone must not count
        drive(1'b0, 4'b0010);
        tick();
        checks++; if (mask !== 4'b1100) begin errors++; $display("[TB] FAIL mask_hold: got %b expected 1100", mask); end
        checks++; if (pulse !== 1'b0) begin errors++; $display("[TB] FAIL nofrog_pulse: got %b expected 0", pulse); end
        tick();
        drive(1'b1, 4'b0000);
        tick();
        checks++; if (mask !== 4'b0000) begin errors++; $display("[TB] FAIL clean_mask: got %b expected 0000", mask); end
        checks++; if (fcol !== 1'b0) begin errors++; $display("[TB] FAIL clean_fcol: got %b expected 0", fcol); end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 4'b0101);
        tick();
        checks++; if (pulse !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first: got %b expected 1", pulse); end
        drive(1'b0, 4'b0000);
        tick();
        // startOfFrame coincides with a frog/hazard-1 overlap
        drive(1'b1, 4'b0011);
        tick();
        checks++; if (mask !== 4'b0100) begin errors++; $display("[TB] FAIL b2b_mask: got %b expected 0100", mask); end
        checks++; if (fcol !== 1'b1) begin errors++; $display("[TB] FAIL b2b_fcol: got %b expected 1", fcol); end
        checks++; if (pulse !== 1'b1) begin errors++; $display("[TB] FAIL b2b_pulse: got %b expected 1", pulse); end
        drive(1'b0, 4'b0011);
        tick();
        checks++; if (pulse !== 1'b0) begin errors++; $display("[TB] FAIL b2b_repeat: got %b expected 0", pulse); end
        drive(1'b0, 4'b0000);
        tick();
        drive(1'b1, 4'b0000);
        tick();
        checks++; if (mask !== 4'b0010) begin errors++; $display("[TB] FAIL b2b_next_mask: got %b expected 0010", mask); end
        checks++; if (fcol !== 1'b1) begin errors++; $display("[TB] FAIL b2b_next_fcol: got %b expected 1", fcol); end
    endtask

    task automatic test_async_reset();
        drive(1'b0, 4'b0101);
        tick();
        checks++; if (pulse !== 1'b1) begin errors++; $display("[TB] FAIL pre_rst_pulse: got %b expected 1", pulse); end
        drive(1'b0, 4'b0000);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (vga !== 8'h00) begin errors++; $display("[TB] FAIL arst_rgb: got %h expected 00", vga); end
        checks++; if (pulse !== 1'b0) begin errors++; $display("[TB] FAIL arst_pulse: got %b expected 0", pulse); end
        checks++; if (mask !== 4'b0000) begin errors++; $display("[TB] FAIL arst_mask: got %b expected 0000", mask); end
        checks++; if (fcol !== 1'b0) begin errors++; $display("[TB] FAIL arst_fcol: got %b expected 0", fcol); end
        #1;
        rst = 1'b0;
        tick();
        drive(1'b0, 4'b1001);
        tick();
        checks++; if (pulse !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_pulse: got %b expected 1", pulse); end
        drive(1'b0, 4'b0000);
        tick();
        checks++; if (pulse !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_single: got %b expected 0", pulse); end
        drive(1'b1, 4'b0000);
        tick();
        checks++; if (mask !== 4'b1000) begin errors++; $display("[TB] FAIL post_rst_mask: got %b expected 1000", mask); end
    endtask

    initial begin
        rst    = 1'b1;
        sof    = 1'b0;
        req    = 4'b0000;
        bg     = 8'h00;
        obj[0] = 8'h00;
        obj[1] = 8'h00;
        obj[2] = 8'h00;
        obj[3] = 8'h00;
        $display("[TB] starting frog_objects_mux bench");
        test_reset();
        test_background();
        test_priority();
        test_transparency();
        test_collision();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
